imem_fetch_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares the single instruction-memory port (PC / instrmem_rd / Instr_dout / complete_instr) between two fetch requesters: the core fetch unit (requester 0) and the debug/program loader (requester 1). It serialises accesses, drives PC and instrmem_rd toward memory, waits for complete_instr, and routes Instr_dout back to the owning requester. A per-access timeout counter converts a missing complete_instr into an error response. The block sits between the requesters and the instruction memory, on the agent-initiator side of the imem bus.

---
 rtl/imem_fetch_arbiter.sv | 74 +++++++
 tb/tb_imem_fetch_arbiter.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/imem_fetch_arbiter.sv
// imem_fetch_arbiter: round-robin sharing of one instruction-memory read port between two fetch requesters,
// with a per-access timeout that turns a missing completion into an error response.
module imem_fetch_arbiter #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        req_valid,
    input  logic [ADDR_W-1:0] req_addr0,
    input  logic [ADDR_W-1:0] req_addr1,
    output logic [1:0]        req_ready,
    output logic [1:0]        rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] PC,
    output logic              instrmem_rd,
    input  logic [DATA_W-1:0] Instr_dout,
    input  logic              complete_instr
);
    localparam int TW = $clog2(TIMEOUT + 1);
    typedef enum logic {IDLE, RD} state_t;
    state_t state, state_nx;
    logic owner, last_grant, grant, tmo;
    logic [TW-1:0] timer;
    always_comb begin
        grant     = (req_valid == 2'b11) ? ~last_grant : req_valid[1];
        req_ready = (rst_n && state == IDLE) ? ((grant ? 2'b10 : 2'b01) & req_valid) : 2'b00;
        tmo       = timer == TW'(TIMEOUT - 1);
        state_nx  = state;
        if (state == IDLE && |req_valid)
            state_nx = RD;
        else if (state == RD && (complete_instr || tmo))
            state_nx = IDLE;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end
    // Completion takes priority over a timeout landing in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            PC          <= '0;
            instrmem_rd <= 1'b0;
            rsp_valid   <= 2'b00;
            rsp_data    <= '0;
            rsp_err     <= 1'b0;
            owner       <= 1'b0;
            last_grant  <= 1'b1;
            timer       <= '0;
        end else begin
            rsp_valid <= 2'b00;
            if (state == IDLE) begin
                if (|req_valid) begin
                    PC          <= grant ? req_addr1 : req_addr0;
                    owner       <= grant;
                    last_grant  <= grant;
                    instrmem_rd <= 1'b1;
                    timer       <= '0;
                end
            end else if (complete_instr || tmo) begin
                rsp_data    <= complete_instr ? Instr_dout : '0;
                rsp_err     <= ~complete_instr;
                rsp_valid   <= owner ? 2'b10 : 2'b01;
                instrmem_rd <= 1'b0;
            end else begin
                timer <= timer + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_imem_fetch_arbiter.sv
// tb_imem_fetch_arbiter: table of whole accesses with hand-computed grants, addresses and responses,
// plus directed sequences for reset, late completion and reset during an access.
module tb_imem_fetch_arbiter;
    localparam int TIMEOUT = 15;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req_valid = 2'b00;
    logic [15:0] req_addr0 = '0, req_addr1 = '0;
    logic [1:0]  req_ready, rsp_valid;
    logic [15:0] rsp_data, PC;
    logic        rsp_err, instrmem_rd;
    logic [15:0] Instr_dout = '0;
    logic        complete_instr = 1'b0;
    int total = 0, bad = 0;

    imem_fetch_arbiter #(.ADDR_W(16), .DATA_W(16), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr0(req_addr0),
        .req_addr1(req_addr1), .req_ready(req_ready), .rsp_valid(rsp_valid),
        .rsp_data(rsp_data), .rsp_err(rsp_err), .PC(PC), .instrmem_rd(instrmem_rd),
        .Instr_dout(Instr_dout), .complete_instr(complete_instr)
    );

    always #5 clk = ~clk;

    // wait_c: RD cycle (1-based) in which completion is driven, 0 = never; edg: edge after accept that registers the response
    typedef struct {
        bit          rst;
        logic [1:0]  rv;
        logic [15:0] a0, a1;
        int          wait_c;
        logic [15:0] dout;
        logic [1:0]  ready;
        logic [15:0] pc;
        logic [1:0]  rsp;
        logic        err;
        logic [15:0] data;
        int          edg;
    } vec_t;
    vec_t tbl[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = 2'b00;
        complete_instr = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_vec(input vec_t v);
        int n;
        bit seen;
        if (v.rst) do_reset();
        req_valid = v.rv;
        req_addr0 = v.a0;
        req_addr1 = v.a1;
        Instr_dout = v.dout;
        #1 chk("req_ready_accept", {30'd0, req_ready}, {30'd0, v.ready});
        @(posedge clk); @(negedge clk);
        chk("rd_strobe", {31'd0, instrmem_rd}, 32'd1);
        chk("pc", {16'd0, PC}, {16'd0, v.pc});
        n = 1;
        seen = 1'b0;
        while (!seen && n < 40) begin
            complete_instr = (n == v.wait_c);
            @(posedge clk); @(negedge clk);
            complete_instr = 1'b0;
            n++;
            if (rsp_valid != 2'b00) seen = 1'b1;
            else chk("req_ready_rd", {30'd0, req_ready}, 32'd0);
        end
        chk("rsp_edge", n - 1, v.edg);
        chk("rsp_valid", {30'd0, rsp_valid}, {30'd0, v.rsp});
        chk("rsp_err", {31'd0, rsp_err}, {31'd0, v.err});
        chk("rsp_data", {16'd0, rsp_data}, {16'd0, v.data});
        chk("rd_low", {31'd0, instrmem_rd}, 32'd0);
    endtask

    initial begin
        tbl[0]  = '{1'b1, 2'b01, 16'h0040, 16'h0000, 1,  16'hA5C3, 2'b01, 16'h0040, 2'b01, 1'b0, 16'hA5C3, 1};
        tbl[1]  = '{1'b1, 2'b11, 16'h0100, 16'h0200, 3,  16'h1111, 2'b01, 16'h0100, 2'b01, 1'b0, 16'h1111, 3};
        tbl[2]  = '{1'b0, 2'b11, 16'h0100, 16'h0200, 3,  16'h2222, 2'b10, 16'h0200, 2'b10, 1'b0, 16'h2222, 3};
        tbl[3]  = '{1'b0, 2'b11, 16'h0100, 16'h0200, 3,  16'h3333, 2'b01, 16'h0100, 2'b01, 1'b0, 16'h3333, 3};
        tbl[4]  = '{1'b0, 2'b11, 16'h0100, 16'h0200, 3,  16'h4444, 2'b10, 16'h0200, 2'b10, 1'b0, 16'h4444, 3};
        tbl[5]  = '{1'b0, 2'b10, 16'h0000, 16'h0300, 2,  16'h5555, 2'b10, 16'h0300, 2'b10, 1'b0, 16'h5555, 2};
        tbl[6]  = '{1'b0, 2'b01, 16'h0400, 16'h0000, 0,  16'hBEEF, 2'b01, 16'h0400, 2'b01, 1'b1, 16'h0000, TIMEOUT};
        tbl[7]  = '{1'b0, 2'b10, 16'h0000, 16'h0500, TIMEOUT, 16'h1234, 2'b10, 16'h0500, 2'b10, 1'b0, 16'h1234, TIMEOUT};
        tbl[8]  = '{1'b0, 2'b01, 16'h1000, 16'h0000, 1,  16'h0A0A, 2'b01, 16'h1000, 2'b01, 1'b0, 16'h0A0A, 1};
        tbl[9]  = '{1'b0, 2'b01, 16'h1002, 16'h0000, 1,  16'h0B0B, 2'b01, 16'h1002, 2'b01, 1'b0, 16'h0B0B, 1};
        tbl[10] = '{1'b0, 2'b01, 16'h1004, 16'h0000, 1,  16'h0C0C, 2'b01, 16'h1004, 2'b01, 1'b0, 16'h0C0C, 1};
        tbl[11] = '{1'b0, 2'b11, 16'h2000, 16'h3000, 1,  16'h7777, 2'b10, 16'h3000, 2'b10, 1'b0, 16'h7777, 1};

        req_valid = 2'b11;
        #1;
        chk("reset_req_ready", {30'd0, req_ready}, 32'd0);
        chk("reset_pc", {16'd0, PC}, 32'd0);
        chk("reset_rd", {31'd0, instrmem_rd}, 32'd0);
        chk("reset_rsp_valid", {30'd0, rsp_valid}, 32'd0);
        chk("reset_rsp_data", {16'd0, rsp_data}, 32'd0);
        chk("reset_rsp_err", {31'd0, rsp_err}, 32'd0);
        @(negedge clk);

        for (int i = 0; i <= 6; i++) run_vec(tbl[i]);

        // completion arriving after a timeout must be dropped
        req_valid = 2'b00;
        complete_instr = 1'b1;
        Instr_dout = 16'hFFFF;
        @(posedge clk); @(negedge clk);
        complete_instr = 1'b0;
        chk("late_rsp_valid", {30'd0, rsp_valid}, 32'd0);
        chk("late_rsp_err", {31'd0, rsp_err}, 32'd1);
        chk("late_rsp_data", {16'd0, rsp_data}, 32'd0);
        chk("late_rd", {31'd0, instrmem_rd}, 32'd0);
        @(negedge clk);
        chk("late_rsp_valid2", {30'd0, rsp_valid}, 32'd0);

        for (int i = 7; i <= 11; i++) run_vec(tbl[i]);

        // reset in the second RD cycle abandons the access
        do_reset();
        req_valid = 2'b01;
        req_addr0 = 16'h0600;
        @(posedge clk); @(negedge clk);
        chk("mid_rd_high", {31'd0, instrmem_rd}, 32'd1);
        @(posedge clk); @(negedge clk);
        rst_n = 1'b0;
        complete_instr = 1'b1;
        #1;
        chk("mid_rd_drop", {31'd0, instrmem_rd}, 32'd0);
        chk("mid_rsp_valid", {30'd0, rsp_valid}, 32'd0);
        chk("mid_pc", {16'd0, PC}, 32'd0);
        repeat (2) @(negedge clk);
        chk("mid_rsp_valid2", {30'd0, rsp_valid}, 32'd0);
        complete_instr = 1'b0;
        req_valid = 2'b11;
        rst_n = 1'b1;
        #1 chk("post_reset_rr", {30'd0, req_ready}, 32'd1);
        run_vec('{1'b0, 2'b10, 16'h0000, 16'h0700, 1, 16'h8888, 2'b10, 16'h0700, 2'b10, 1'b0, 16'h8888, 1});
        req_valid = 2'b00;
        @(negedge clk);
        chk("final_rsp_valid", {30'd0, rsp_valid}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
